// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the memory-port arbiter
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        DACCESS,
        IDONE,
        DDONE
    } arb_state_t;

    // Round-robin flag records which side was served last.
    localparam logic GNT_INSTR = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int TMO_W           = 8;

    function automatic logic grant_data(input logic instr_req, input logic data_req,
                                        input logic last_gnt);
        return data_req && (!instr_req || last_gnt == GNT_INSTR);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating wait counter with expiry flag
module mem_timeout_ctr #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && r_count != W'(LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between instruction fetch and data access
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instrreq,
    input  logic [31:0]  instradr,
    output logic [31:0]  instr,
    output logic         instrabort,
    input  logic         datareq,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    input  logic [1:0]   memwriteM,
    output logic [N-1:0] readdata,
    output logic         dataabort,
    output logic         mem_req,
    output logic [1:0]   mem_we,
    output logic [N-1:0] mem_adr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         buserr
);
    arb_state_t   r_state;
    logic         r_rr;
    logic         r_flush;
    logic         r_mem_req;
    logic         r_buserr;
    logic [1:0]   r_mem_we;
    logic [N-1:0] r_mem_adr;
    logic [N-1:0] r_mem_wdata;
    logic [N-1:0] r_buf;
    logic [N-1:0] r_readdata;
    logic [31:0]  r_instr;

    logic         w_grant_data;
    logic         w_grant_instr;
    logic         w_dside;
    logic         w_req_live;
    logic         w_flushed;
    logic         w_ack;
    logic         w_wait;
    logic         w_expired;
    logic         w_timeout;
    logic [31:0]  w_instr_sel;

    assign w_grant_data  = (r_state == IDLE) && grant_data(instrreq, datareq, r_rr);
    assign w_grant_instr = (r_state == IDLE) && instrreq && !w_grant_data;
    assign w_dside       = (r_state == DACCESS);
    assign w_req_live    = w_dside ? datareq : instrreq;
    assign w_flushed     = r_flush || !w_req_live;
    // An ack only counts while a request is actually on the bus.
    assign w_ack         = r_mem_req && mem_ack;
    assign w_wait        = r_mem_req && !mem_ack;
    assign w_timeout     = w_wait && w_expired;
    assign w_instr_sel   = instradr[2] ? r_buf[63:32] : r_buf[31:0];

    mem_timeout_ctr #(
        .W     (TMO_W),
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clr     (w_grant_data || w_grant_instr),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rr        <= GNT_INSTR;
            r_flush     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 2'b00;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
            r_buf       <= '0;
            r_readdata  <= '0;
            r_instr     <= '0;
            r_buserr    <= 1'b0;
        end else begin
            r_buserr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_flush <= 1'b0;
                    if (w_grant_data) begin
                        r_state     <= DACCESS;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= memwriteM;
                        r_mem_adr   <= dataadr;
                        r_mem_wdata <= writedata;
                    end else if (w_grant_instr) begin
                        r_state     <= IFETCH;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 2'b00;
                        r_mem_adr   <= N'(instradr);
                        r_mem_wdata <= '0;
                    end
                end
                IFETCH, DACCESS: begin
                    if (!w_req_live) begin
                        r_flush <= 1'b1;
                    end
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        r_rr      <= w_dside ? GNT_DATA : GNT_INSTR;
                        // A flushed access still has to finish on the bus, but its data is dropped.
                        if (w_flushed) begin
                            r_state <= IDLE;
                        end else begin
                            r_buf   <= mem_rdata;
                            r_state <= w_dside ? DDONE : IDONE;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_rr      <= w_dside ? GNT_DATA : GNT_INSTR;
                        r_buf     <= '0;
                        r_buserr  <= 1'b1;
                        r_state   <= w_dside ? DDONE : IDONE;
                    end
                end
                IDONE: begin
                    r_instr <= w_instr_sel;
                    r_state <= IDLE;
                end
                DDONE: begin
                    r_readdata <= r_buf;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign instr      = (r_state == IDONE) ? w_instr_sel : r_instr;
    assign readdata   = (r_state == DDONE) ? r_buf : r_readdata;
    assign instrabort = instrreq && (r_state != IDONE);
    assign dataabort  = datareq && (r_state != DDONE);
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_adr    = r_mem_adr;
    assign mem_wdata  = r_mem_wdata;
    assign buserr     = r_buserr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset, instrreq, datareq, mem_ack;
    logic [31:0] instradr, instr;
    logic        instrabort, dataabort, mem_req, buserr;
    logic [63:0] dataadr, writedata, readdata, mem_adr, mem_wdata, mem_rdata;
    logic [1:0]  memwriteM, mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.N(64), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .instrreq(instrreq), .instradr(instradr), .instr(instr), .instrabort(instrabort),
        .datareq(datareq), .dataadr(dataadr), .writedata(writedata), .memwriteM(memwriteM),
        .readdata(readdata), .dataabort(dataabort),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .buserr(buserr)
    );

    typedef struct packed {
        logic        is_data;
        logic [63:0] val;
        logic        berr;
    } done_t;

    typedef struct packed {
        logic [63:0] adr;
        logic [1:0]  we;
        logic [63:0] wd;
        logic        chk_wd;
    } bus_t;

    done_t       q_done[$];
    bus_t        q_bus[$];
    logic [63:0] q_rdata[$];

    int total = 0;
    int bad = 0;
    int berr_cnt = 0;
    bit resp_en = 0;
    int resp_wait = 0;
    int resp_cnt = 0;

    logic        m_prev_req, m_prev_idone, m_prev_ddone;
    logic [63:0] m_adr, m_wd;
    logic [1:0]  m_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic [63:0] adr, input logic [1:0] we, input logic [63:0] wd,
                           input logic chk);
        bus_t b;
        b.adr = adr; b.we = we; b.wd = wd; b.chk_wd = chk;
        q_bus.push_back(b);
    endtask

    task automatic exp_done(input logic is_data, input logic [63:0] val, input logic berr);
        done_t d;
        d.is_data = is_data; d.val = val; d.berr = berr;
        q_done.push_back(d);
    endtask

    task automatic wait_done(input bit is_data, input int max, output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < max) begin
            @(negedge clk);
            if (is_data ? (datareq && !dataabort) : (instrreq && !instrabort)) found = 1;
            else n++;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL wait_done: no completion within %0d cycles (data=%0d)", max, is_data);
        end
    endtask

    task automatic wait_req(input bit level, input int max);
        int n;
        n = 0;
        while (mem_req !== level && n < max) begin
            @(negedge clk);
            n++;
        end
        if (mem_req !== level) begin
            total++; bad++;
            $display("FAIL wait_req: mem_req=%b required %b within %0d cycles", mem_req, level, max);
        end
    endtask

    // Bus responder: acks after resp_wait stall cycles, rdata from q_rdata.
    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (mem_req) begin
                    if (resp_cnt == resp_wait) begin
                        mem_ack   = 1'b1;
                        mem_rdata = (q_rdata.size() != 0) ? q_rdata.pop_front() : 64'h0;
                        resp_cnt  = 0;
                    end else begin
                        mem_ack  = 1'b0;
                        resp_cnt++;
                    end
                end else begin
                    mem_ack  = 1'b0;
                    resp_cnt = 0;
                end
            end
        end
    end

    initial begin : monitor
        bus_t  b;
        done_t d;
        logic  idone, ddone;
        m_prev_req = 0; m_prev_idone = 0; m_prev_ddone = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_prev_req = 0; m_prev_idone = 0; m_prev_ddone = 0;
            end else begin
                if (buserr === 1'b1) berr_cnt++;
                if (mem_req && !m_prev_req) begin
                    if (q_bus.size() == 0) begin
                        total++; bad++;
                        $display("FAIL bus_unexpected: mem_adr=%h with no access expected", mem_adr);
                    end else begin
                        b = q_bus.pop_front();
                        check("bus_adr", mem_adr, b.adr);
                        check("bus_we", mem_we, b.we);
                        if (b.chk_wd) check("bus_wdata", mem_wdata, b.wd);
                    end
                    m_adr = mem_adr; m_we = mem_we; m_wd = mem_wdata;
                end else if (mem_req && m_prev_req) begin
                    check("bus_adr_hold", mem_adr, m_adr);
                    check("bus_we_hold", mem_we, m_we);
                    check("bus_wdata_hold", mem_wdata, m_wd);
                end
                m_prev_req = mem_req;
                idone = instrreq && !instrabort;
                ddone = datareq && !dataabort;
                if (idone || ddone) begin
                    check(idone ? "instrabort_width" : "dataabort_width",
                          idone ? m_prev_idone : m_prev_ddone, 0);
                    if (q_done.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_unexpected: completion (data=%0d) with none expected", ddone);
                    end else begin
                        d = q_done.pop_front();
                        check("done_side", ddone, d.is_data);
                        if (ddone) check("readdata", readdata, d.val);
                        else check("instr", instr, d.val);
                        check("done_buserr", buserr, d.berr);
                        check("done_mem_req", mem_req, 0);
                    end
                end
                m_prev_idone = idone;
                m_prev_ddone = ddone;
            end
        end
    end

    initial begin : watchdog
        #200000;
        total++; bad++;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        logic [63:0] rk;
        reset = 0; instrreq = 0; datareq = 0; mem_ack = 0; mem_rdata = 0;
        instradr = 0; dataadr = 0; writedata = 0; memwriteM = 0;
        repeat (2) @(posedge clk);
        #1;
        instrreq = 1; datareq = 1;
        #1;
        check("rst_instrabort", instrabort, 1);
        check("rst_dataabort", dataabort, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_adr", mem_adr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_instr", instr, 0);
        check("rst_readdata", readdata, 0);
        check("rst_buserr", buserr, 0);
        instrreq = 0; datareq = 0;
        @(posedge clk); #1; reset = 1;

        // Fetch at 0x104, two stall cycles: upper half selected.
        resp_en = 1; resp_wait = 2;
        q_rdata.push_back(64'hAABBCCDD_11223344);
        exp_bus(64'h104, 2'b00, 64'h0, 0);
        exp_done(0, 64'hAABBCCDD, 0);
        @(posedge clk); #1; instradr = 32'h0000_0104; instrreq = 1;
        wait_done(0, 30, n);
        @(posedge clk); #1; instrreq = 0; instradr = 32'h0;
        @(negedge clk); check("instr_hold", instr, 32'hAABBCCDD);

        // Fetch at 0x100, ack on first request cycle: lower half, minimum latency.
        resp_wait = 0;
        q_rdata.push_back(64'h01234567_89ABCDEF);
        exp_bus(64'h100, 2'b00, 64'h0, 0);
        exp_done(0, 64'h89ABCDEF, 0);
        @(posedge clk); #1; instradr = 32'h0000_0100; instrreq = 1;
        wait_done(0, 30, n);
        check("min_latency", n + 1, 3);
        @(posedge clk); #1; instrreq = 0;

        // Store: bus fields latched even when core inputs move.
        resp_wait = 3;
        q_rdata.push_back(64'hDEADBEEF_00000001);
        exp_bus(64'h40, 2'b01, 64'h55, 1);
        exp_done(1, 64'hDEADBEEF_00000001, 0);
        @(posedge clk); #1; datareq = 1; memwriteM = 2'b01; dataadr = 64'h40; writedata = 64'h55;
        @(negedge clk); @(negedge clk);
        dataadr = 64'h48; writedata = 64'h66; memwriteM = 2'b10;
        wait_done(1, 30, n);
        @(posedge clk); #1; datareq = 0; memwriteM = 0;

        // Flush: data request dropped mid-access, ack three cycles later.
        resp_wait = 4;
        q_rdata.push_back(64'hBAD0BAD0_BAD0BAD0);
        exp_bus(64'h20, 2'b00, 64'h0, 0);
        @(posedge clk); #1; datareq = 1; dataadr = 64'h20; writedata = 64'h0;
        wait_req(1, 10);
        @(posedge clk); #1; datareq = 0;
        wait_req(0, 20);
        @(negedge clk);
        check("flush_readdata", readdata, 64'hDEADBEEF_00000001);
        check("flush_mem_req", mem_req, 0);

        // Stray ack with no request outstanding.
        resp_en = 0;
        @(posedge clk); #1; mem_ack = 1; mem_rdata = 64'h12345678_9ABCDEF0;
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        check("stray_ack_readdata", readdata, 64'hDEADBEEF_00000001);
        check("stray_ack_instr", instr, 32'h89ABCDEF);
        check("stray_ack_mem_req", mem_req, 0);

        // Timeout: no ack ever.
        exp_bus(64'h80, 2'b00, 64'h0, 0);
        exp_done(1, 64'h0, 1);
        @(posedge clk); #1; datareq = 1; dataadr = 64'h80;
        wait_done(1, 400, n);
        @(posedge clk); #1; datareq = 0;
        @(negedge clk); check("timeout_readdata_hold", readdata, 64'h0);

        // Ack lands in the same cycle the counter expires: ack wins.
        resp_en = 1; resp_wait = 255;
        q_rdata.push_back(64'h5A5A5A5A_A5A5A5A5);
        exp_bus(64'h88, 2'b00, 64'h0, 0);
        exp_done(1, 64'h5A5A5A5A_A5A5A5A5, 0);
        @(posedge clk); #1; datareq = 1; dataadr = 64'h88;
        wait_done(1, 400, n);
        @(posedge clk); #1; datareq = 0;

        // Both sides requesting from reset: data first, then alternate.
        reset = 0;
        @(posedge clk); #1; reset = 1;
        resp_wait = 0;
        instradr = 32'h8; dataadr = 64'h10; writedata = 64'h77; memwriteM = 2'b00;
        for (int k = 0; k < 4; k++) begin
            rk = {32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k)};
            q_rdata.push_back(rk);
            if (k % 2 == 0) begin
                exp_bus(64'h10, 2'b00, 64'h77, 1);
                exp_done(1, rk, 0);
            end else begin
                exp_bus(64'h8, 2'b00, 64'h0, 0);
                exp_done(0, {32'h0, rk[31:0]}, 0);
            end
        end
        @(posedge clk); #1; instrreq = 1; datareq = 1;
        for (int k = 0; k < 4; k++) begin
            wait_done(k % 2 == 0, 30, n);
        end
        @(posedge clk); #1; instrreq = 0; datareq = 0;

        // Reset in the middle of a data access.
        resp_en = 0; mem_ack = 0;
        exp_bus(64'h30, 2'b00, 64'h0, 0);
        @(posedge clk); #1; datareq = 1; dataadr = 64'h30; writedata = 64'h0;
        wait_req(1, 10);
        @(posedge clk); #2; reset = 0;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_dataabort", dataabort, 1);
        check("async_rst_readdata", readdata, 0);
        datareq = 0;
        @(posedge clk); #1; reset = 1;
        mem_ack = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1; mem_ack = 0;
        @(negedge clk);
        check("late_ack_mem_req", mem_req, 0);
        check("late_ack_readdata", readdata, 0);

        // Arbiter must be back in IDLE: a fresh fetch completes at minimum latency.
        resp_en = 1; resp_wait = 0;
        q_rdata.push_back(64'h00000000_CAFEF00D);
        exp_bus(64'h10, 2'b00, 64'h0, 0);
        exp_done(0, 64'hCAFEF00D, 0);
        @(posedge clk); #1; instradr = 32'h10; instrreq = 1;
        wait_done(0, 30, n);
        check("post_reset_latency", n + 1, 3);
        @(posedge clk); #1; instrreq = 0;
        repeat (3) @(negedge clk);

        check("buserr_pulses", berr_cnt, 1);
        check("done_queue_empty", q_done.size(), 0);
        check("bus_queue_empty", q_bus.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
